// File: rtl/arduino_note_tx_if.sv
// Note-transmitter handshake bundle: request strobe and note select in,
// serial line, busy/done/dropped status and debug state code out.
interface arduino_note_tx_if;
  logic       activate;
  logic [6:0] nota;
  logic       tx;
  logic       busy;
  logic       done;
  logic       dropped;
  logic [2:0] db_estado;

  modport master (
    output activate,
    output nota,
    input  tx,
    input  busy,
    input  done,
    input  dropped,
    input  db_estado
  );

  modport slave (
    input  activate,
    input  nota,
    output tx,
    output busy,
    output done,
    output dropped,
    output db_estado
  );
endinterface

// File: rtl/arduino_note_tx.sv
// arduino_note_tx: encodes a one-hot note as ASCII and sends it 8N1
// (8E1 with ARDUINO_TX_PARITY_EN) on bus.tx, with a one-entry pending slot.
// Ports: clock, reset (async, active low); bus.activate/nota in;
// bus.tx/busy/done/dropped/db_estado out.
module arduino_note_tx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic             clock,
  input  logic             reset,
  arduino_note_tx_if.slave bus
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int BW  = $clog2(CPB);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          pend_q, pend_d;
  logic [7:0]    pbyte_q, pbyte_d;
  logic          act_q;
  logic          done_q, done_d;
  logic          drop_q, drop_d;

  logic [7:0] enc;
  logic [2:0] hits;
  logic       req;
  logic       idle;
  logic       bit_end;
  logic       launch_pend;
  logic       launch_req;
  logic       store;

  always_comb begin
    enc  = 8'h30;
    hits = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (bus.nota[i]) begin
        hits = hits + 3'd1;
        enc  = 8'h31 + 8'(i);
      end
    end
    if (hits > 3'd1) enc = 8'h3F;
  end

  assign req     = bus.activate & ~act_q;
  assign idle    = (state_q == IDLE);
  assign bit_end = (baud_q == BW'(CPB - 1));

  // The pending byte can leave from IDLE or straight out of STOP, so a
  // queued frame follows the stop bit with no idle gap.
  assign launch_pend = pend_q &
    (idle | ((state_q == STOP) & bit_end));
  // A request during the done cycle is queued, not launched directly.
  assign launch_req = idle & ~pend_q & req & ~done_q;
  assign store = req & ~launch_req;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pend_d  = pend_q;
    pbyte_d = pbyte_q;
    done_d  = 1'b0;
    drop_d  = drop_q;

    if (!idle) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (launch_pend | launch_req) state_d = START;
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef ARDUINO_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = pend_q ? START : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch_req) shreg_d = enc;
    if (launch_pend) begin
      shreg_d = pbyte_q;
      pend_d  = 1'b0;
    end

    if (store) begin
      if (!pend_q || launch_pend) begin
        pend_d  = 1'b1;
        pbyte_d = enc;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      pend_q  <= 1'b0;
      pbyte_q <= 8'h00;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      pend_q  <= pend_d;
      pbyte_q <= pbyte_d;
      act_q   <= bus.activate;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  // Line level is decoded from registered state, so reset forces it high.
  logic tx_c;
  always_comb begin
    tx_c = 1'b1;
    unique case (state_q)
      START:   tx_c = 1'b0;
      DATA:    tx_c = shreg_q[bit_q];
      PARITY:  tx_c = ^shreg_q;
      default: tx_c = 1'b1;
    endcase
  end

  assign bus.tx        = tx_c;
  assign bus.busy      = ~idle | pend_q;
  assign bus.done      = done_q;
  assign bus.dropped   = drop_q;
  assign bus.db_estado = state_q;

endmodule

// File: tb/tb_arduino_note_tx.sv
// Self-checking bench for arduino_note_tx at CLKS_PER_BIT = 4.
// Directed vector table plus pending, overflow and mid-frame reset cases.
module tb_arduino_note_tx;

`ifdef ARDUINO_TX_PARITY_EN
  localparam int SO = 40;
`else
  localparam int SO = 36;
`endif
  localparam int FL = SO + 4;
  localparam int NL = 128;

  logic clk;
  logic rst_n;

  arduino_note_tx_if u_if ();

  arduino_note_tx #(
    .CLK_HZ (40),
    .BAUD   (10)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [6:0] nota;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[6];

  logic       tx_l[NL];
  logic       busy_l[NL];
  logic       done_l[NL];
  logic       drop_l[NL];
  logic [2:0] db_l[NL];

  int checks;
  int errors;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic capture(input int ncyc,
                         input int c0, input int c1,
                         input int c2,
                         input logic [6:0] n0,
                         input logic [6:0] n1,
                         input logic [6:0] n2);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      tx_l[c]   = u_if.tx;
      busy_l[c] = u_if.busy;
      done_l[c] = u_if.done;
      drop_l[c] = u_if.dropped;
      db_l[c]   = u_if.db_estado;
      if (c == c0) begin
        u_if.nota = n0;
        u_if.activate = 1'b1;
      end else if (c == c1) begin
        u_if.nota = n1;
        u_if.activate = 1'b1;
      end else if (c == c2) begin
        u_if.nota = n2;
        u_if.activate = 1'b1;
      end else begin
        u_if.activate = 1'b0;
      end
    end
    u_if.activate = 1'b0;
  endtask

  function automatic logic [7:0] get_byte(input int s);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = tx_l[s + 5 + 4 * j];
    return b;
  endfunction

  function automatic int first_done(input int from);
    for (int c = from; c < NL; c++)
      if (done_l[c] === 1'b1) return c;
    return -1;
  endfunction

  function automatic int framing(input int s,
                                 input logic [7:0] b);
    int ok;
    ok = 1;
    for (int k = 0; k < 4; k++) begin
      if (tx_l[s + k] !== 1'b0) ok = 0;
`ifdef ARDUINO_TX_PARITY_EN
      if (tx_l[s + 36 + k] !== ^b) ok = 0;
`endif
      if (tx_l[s + SO + k] !== 1'b1) ok = 0;
    end
    return ok;
  endfunction

  int ok;

  initial begin
    checks = 0;
    errors = 0;
    vt[0] = '{7'b0000100, 8'h33};
    vt[1] = '{7'b0000000, 8'h30};
    vt[2] = '{7'b0010010, 8'h3F};
    vt[3] = '{7'b0000001, 8'h31};
    vt[4] = '{7'b1000000, 8'h37};
    vt[5] = '{7'b1111111, 8'h3F};

    rst_n = 1'b0;
    u_if.activate = 1'b0;
    u_if.nota = 7'd0;
    repeat (2) @(negedge clk);
    chk("rst_tx", int'(u_if.tx), 1);
    chk("rst_busy", int'(u_if.busy), 0);
    chk("rst_done", int'(u_if.done), 0);
    chk("rst_dropped", int'(u_if.dropped), 0);
    chk("rst_state", int'(u_if.db_estado), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      capture(60, 0, -1, -1, vt[v].nota, 7'd0, 7'd0);
      chk($sformatf("v%0d_byte", v),
          int'(get_byte(1)), int'(vt[v].exp));
      chk($sformatf("v%0d_frame", v),
          framing(1, vt[v].exp), 1);
      chk($sformatf("v%0d_idle0", v), int'(tx_l[0]), 1);
      chk($sformatf("v%0d_done", v), first_done(0), FL + 1);
      chk($sformatf("v%0d_busy1", v), int'(busy_l[1]), 1);
      chk($sformatf("v%0d_busyL", v), int'(busy_l[FL]), 1);
      chk($sformatf("v%0d_busyE", v),
          int'(busy_l[FL + 1]), 0);
      chk($sformatf("v%0d_stS", v), int'(db_l[1]), 1);
      chk($sformatf("v%0d_stD", v), int'(db_l[5]), 2);
`ifdef ARDUINO_TX_PARITY_EN
      chk($sformatf("v%0d_stP", v), int'(db_l[37]), 3);
`endif
      chk($sformatf("v%0d_stT", v), int'(db_l[FL - 3]), 4);
    end

    capture(100, 0, 10, -1, 7'b0000001, 7'b1000000, 7'd0);
    chk("pend_b1", int'(get_byte(1)), 8'h31);
    chk("pend_f1", framing(1, 8'h31), 1);
    chk("pend_d1", first_done(0), FL + 1);
    chk("pend_b2", int'(get_byte(FL + 1)), 8'h37);
    chk("pend_f2", framing(FL + 1, 8'h37), 1);
    chk("pend_d2", first_done(FL + 2), 2 * FL + 1);
    ok = 1;
    for (int c = 1; c <= 2 * FL; c++)
      if (busy_l[c] !== 1'b1) ok = 0;
    chk("pend_busy", ok, 1);
    chk("pend_busyE", int'(busy_l[2 * FL + 1]), 0);
    chk("pend_drop", int'(drop_l[99]), 0);

    capture(110, 0, 8, 16, 7'b0000100, 7'b0001000,
            7'b0010000);
    chk("ovf_b1", int'(get_byte(1)), 8'h33);
    chk("ovf_b2", int'(get_byte(FL + 1)), 8'h34);
    chk("ovf_f2", framing(FL + 1, 8'h34), 1);
    chk("ovf_d2", first_done(FL + 2), 2 * FL + 1);
    chk("ovf_drop15", int'(drop_l[15]), 0);
    chk("ovf_drop17", int'(drop_l[17]), 1);
    chk("ovf_drop_end", int'(drop_l[109]), 1);
    chk("ovf_busy_end", int'(busy_l[109]), 0);
    ok = 1;
    for (int c = 2 * FL + 1; c < 110; c++)
      if (tx_l[c] !== 1'b1) ok = 0;
    chk("ovf_no3rd", ok, 1);

    @(negedge clk);
    u_if.nota = 7'b0000010;
    u_if.activate = 1'b1;
    @(negedge clk);
    u_if.activate = 1'b0;
    repeat (16) @(negedge clk);
    chk("mid_state", int'(u_if.db_estado), 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_tx", int'(u_if.tx), 1);
    chk("mid_busy", int'(u_if.busy), 0);
    chk("mid_state0", int'(u_if.db_estado), 0);
    chk("mid_dropped", int'(u_if.dropped), 0);
    chk("mid_done", int'(u_if.done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    capture(60, 2, -1, -1, 7'b0100000, 7'd0, 7'd0);
    chk("post_idle", int'(tx_l[2]), 1);
    chk("post_byte", int'(get_byte(3)), 8'h36);
    chk("post_frame", framing(3, 8'h36), 1);
    chk("post_done", first_done(0), FL + 3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
